count_lcd_writer: RTL and testbench
===================================

# count_lcd_writer

Downstream consumer of the 4-bit event counter: takes each new 4-bit count value and shows it as one ASCII hex character at DDRAM address 0 of an HD44780-compatible character LCD. The LCD runs in 4-bit bus mode. After reset the block runs the LCD power-on initialisation itself, then accepts values through a valid/ready handshake. It owns all LCD bus pins; the counter side sees only the handshake.

## Interface
- E_PULSE_CYC, default 12: clocks lcd_e is held high per nibble. This is also the gap after a high nibble.
- CMD_WAIT_CYC, default 2000: idle clocks after the low nibble of a normal command or data byte.
- CLR_WAIT_CYC, default 82000: idle clocks after each init nibble and after the clear-display command.
- POR_WAIT_CYC, default 750000: idle clocks after reset before the first init nibble.
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- value_in  in  4  count value to display; sampled on the accepting edge.
- value_valid  in  1  offer strobe; a transfer occurs when value_valid=1 and ready=1 at a rising edge.
- ready  out  1  block is idle and can accept a value.
- init_done  out  1  LCD initialisation is complete; stays high until the next reset.
- lcd_rs  out  1  register select: 0 = command, 1 = data.
- lcd_rw  out  1  read/write select; tied 0 (write only).
- lcd_e  out  1  LCD enable strobe.
- lcd_d  out  4  LCD data nibble (DB7..DB4).

## Operation
- Reset values: ready=0, init_done=0, lcd_rs=0, lcd_rw=0, lcd_e=0, lcd_d=0.
- Top FSM states: POR_WAIT, INIT, IDLE, WR_ADDR, WR_CHAR.
- Nibble sub-sequence, used by every write:
  - SETUP: 1 cycle; lcd_rs and lcd_d driven, lcd_e=0.
  - PULSE: E_PULSE_CYC cycles with lcd_e=1.
  - HOLD: 1 cycle; lcd_e=0, lcd_rs and lcd_d unchanged.
  - WAIT: the applicable wait count.
- Byte write: high nibble first, with WAIT = E_PULSE_CYC; then low nibble, with WAIT = CMD_WAIT_CYC, or CLR_WAIT_CYC for the clear command.
- POR_WAIT: count POR_WAIT_CYC cycles, then go to INIT.
- INIT, all with RS=0:
  - Single nibbles 0x3, 0x3, 0x3, 0x2, each followed by CLR_WAIT_CYC.
  - Then bytes 0x28, 0x0C, 0x01 (clear, uses CLR_WAIT_CYC), 0x06.
  - Then init_done=1, ready=1, go to IDLE.
- IDLE: ready=1. On a transfer, capture value_in, drop ready, go to WR_ADDR.
- WR_ADDR: write byte 0x80 with RS=0, then go to WR_CHAR.
- WR_CHAR: write the ASCII of the captured value with RS=1, then return to IDLE.
  - Values 0..9 map to 0x30..0x39.
  - Values A..F map to 0x41..0x46.
- value_valid while ready=0 is ignored. The block does not queue; the upstream stage must hold or re-offer the value.
- Reset at any point, mid-pulse included: the next edge forces the reset values and restarts POR_WAIT.
- All wait counters are wide enough for the largest parameter (at least 20 bits) and never wrap.

## Timing
- ready is combinational from state (ready = state==IDLE). It falls on the edge after acceptance.
- One nibble costs 2+E_PULSE_CYC+wait cycles.
- A normal byte costs 4+3·E_PULSE_CYC+CMD_WAIT_CYC cycles.
- After an accepting edge, ready returns to 1 exactly 2·(4+3·E_PULSE_CYC+CMD_WAIT_CYC) cycles later.
- lcd_d and lcd_rs never change while lcd_e=1.
- lcd_e is registered and glitch-free.
- First lcd_e rise occurs POR_WAIT_CYC+1 cycles after reset deasserts.

## Configuration
- COUNT_LCD_DEDUP_EN defined: the block keeps a last-displayed register (invalid after reset).
  - A transfer whose value equals that register is accepted, produces no bus activity, and ready stays 1.
  - The first value after reset is always written.
- COUNT_LCD_DEDUP_EN undefined: every accepted value triggers the full WR_ADDR/WR_CHAR sequence.

## Test plan
All scenarios use E_PULSE_CYC=2, CMD_WAIT_CYC=5, CLR_WAIT_CYC=10, POR_WAIT_CYC=20.
- Reset release: lcd_e stays 0 for 20 cycles. Captured nibbles on lcd_e falling edges are 3,3,3,2,2,8,0,C,0,1,0,6, all with RS=0. Then init_done=1 and ready=1.
- After init, offer value 0x7 for one cycle:
  - Nibbles 8,0 with RS=0, then 3,7 with RS=1.
  - ready returns to 1 exactly 30 cycles after the accepting edge.
- Offer 0xA, then 0xF: data nibbles are 4,1 then 4,6.
- value_valid pulsed while ready=0 during a write: no extra bus activity; the only data written is the accepted value.
- Assert reset during the PULSE of the character high nibble: next cycle lcd_e=0, ready=0, init_done=0, and the full init sequence reruns.
- Offer 0x5 twice:
  - With COUNT_LCD_DEDUP_EN defined, the second transfer produces no lcd_e pulses and ready stays 1.
  - With it undefined, the second transfer produces a full 4-nibble write.

Source files
------------

// File: rtl/count_lcd_writer.sv
// Shows each accepted 4-bit count as one ASCII hex character at DDRAM address 0 of an HD44780 LCD (4-bit bus).
// Optional macro COUNT_LCD_DEDUP_EN: skip the bus write when the value equals the last one displayed.
module count_lcd_writer #(
  parameter int unsigned E_PULSE_CYC  = 12,
  parameter int unsigned CMD_WAIT_CYC = 2000,
  parameter int unsigned CLR_WAIT_CYC = 82000,
  parameter int unsigned POR_WAIT_CYC = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] value_in,
  input  logic       value_valid,
  output logic       ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] lcd_d
);

  localparam int unsigned MAX_AB  = (E_PULSE_CYC > CMD_WAIT_CYC) ? E_PULSE_CYC : CMD_WAIT_CYC;
  localparam int unsigned MAX_CD  = (CLR_WAIT_CYC > POR_WAIT_CYC) ? CLR_WAIT_CYC : POR_WAIT_CYC;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CLOG_W  = $clog2(MAX_CYC + 1);
  localparam int unsigned CNT_W   = (CLOG_W > 32'd20) ? CLOG_W : 32'd20;
  localparam int unsigned STEP_W  = 4;

  typedef enum logic [2:0] {POR_WAIT, INIT, IDLE, WR_ADDR, WR_CHAR} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD, PH_WAIT} phase_t;
  typedef enum logic [1:0] {W_PULSE, W_CMD, W_CLR} wsel_t;

  typedef struct packed {
    logic       rs;
    wsel_t      wsel;
    logic [3:0] d;
  } nib_t;

  state_t              state;
  phase_t              phase;
  wsel_t               wsel_q;
  logic [STEP_W-1:0]   step;
  logic [CNT_W-1:0]    cnt;
  logic [3:0]          val_q;

  state_t              tgt_state;
  logic [STEP_W-1:0]   tgt_step;
  nib_t                tgt_nib;
  logic [7:0]          ascii_c;
  logic [CNT_W-1:0]    wait_len_c;
  logic                pulse_last_c;
  logic                wait_last_c;
  logic                load_c;
  logic                dup_c;

  // Nibble schedule: what each step of each write sequence puts on the bus and how long it waits.
  function automatic nib_t nib_info(input state_t st, input logic [STEP_W-1:0] stp,
                                    input logic [7:0] ch);
    nib_t n;
    n = '{rs: 1'b0, wsel: W_CMD, d: 4'h0};
    case (st)
      INIT: begin
        case (stp)
          4'd0, 4'd1, 4'd2: begin n.d = 4'h3; n.wsel = W_CLR;   end
          4'd3:             begin n.d = 4'h2; n.wsel = W_CLR;   end
          4'd4:             begin n.d = 4'h2; n.wsel = W_PULSE; end
          4'd5:             begin n.d = 4'h8; n.wsel = W_CMD;   end
          4'd6:             begin n.d = 4'h0; n.wsel = W_PULSE; end
          4'd7:             begin n.d = 4'hC; n.wsel = W_CMD;   end
          4'd8:             begin n.d = 4'h0; n.wsel = W_PULSE; end
          4'd9:             begin n.d = 4'h1; n.wsel = W_CLR;   end
          4'd10:            begin n.d = 4'h0; n.wsel = W_PULSE; end
          4'd11:            begin n.d = 4'h6; n.wsel = W_CMD;   end
          default: ;
        endcase
      end
      WR_ADDR: begin
        n.d    = (stp == 4'd0) ? 4'h8 : 4'h0;
        n.wsel = (stp == 4'd0) ? W_PULSE : W_CMD;
      end
      WR_CHAR: begin
        n.rs   = 1'b1;
        n.d    = (stp == 4'd0) ? ch[7:4] : ch[3:0];
        n.wsel = (stp == 4'd0) ? W_PULSE : W_CMD;
      end
      default: ;
    endcase
    return n;
  endfunction

  assign ascii_c = (val_q < 4'd10) ? (8'h30 + 8'(val_q)) : (8'h37 + 8'(val_q));

`ifdef COUNT_LCD_DEDUP_EN
  logic [3:0] last_val;
  logic       last_vld;

  assign dup_c = last_vld && (value_in == last_val);

  // Remembers what is on the display so repeats can be absorbed without bus traffic.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_val <= 4'h0;
      last_vld <= 1'b0;
    end else if (state == IDLE && value_valid) begin
      last_val <= value_in;
      last_vld <= 1'b1;
    end
  end
`else
  assign dup_c = 1'b0;
`endif

  always_comb begin
    wait_len_c = CNT_W'(CMD_WAIT_CYC);
    case (wsel_q)
      W_PULSE: wait_len_c = CNT_W'(E_PULSE_CYC);
      W_CLR:   wait_len_c = CNT_W'(CLR_WAIT_CYC);
      default: wait_len_c = CNT_W'(CMD_WAIT_CYC);
    endcase
  end

  assign pulse_last_c = (cnt == CNT_W'(E_PULSE_CYC - 1));
  assign wait_last_c  = (cnt == (wait_len_c - CNT_W'(1)));

  // Where the sequence goes when the current nibble (or POR wait, or idle acceptance) finishes.
  always_comb begin
    tgt_state = state;
    tgt_step  = step + 4'd1;
    load_c    = 1'b0;
    case (state)
      POR_WAIT: begin
        tgt_state = INIT;
        tgt_step  = '0;
        load_c    = (cnt == CNT_W'(POR_WAIT_CYC - 1));
      end
      INIT: begin
        if (step == 4'd11) begin
          tgt_state = IDLE;
          tgt_step  = '0;
        end
        load_c = (phase == PH_WAIT) && wait_last_c;
      end
      IDLE: begin
        tgt_state = WR_ADDR;
        tgt_step  = '0;
        load_c    = value_valid && !dup_c;
      end
      WR_ADDR: begin
        if (step == 4'd1) begin
          tgt_state = WR_CHAR;
          tgt_step  = '0;
        end
        load_c = (phase == PH_WAIT) && wait_last_c;
      end
      WR_CHAR: begin
        if (step == 4'd1) begin
          tgt_state = IDLE;
          tgt_step  = '0;
        end
        load_c = (phase == PH_WAIT) && wait_last_c;
      end
      default: ;
    endcase
    tgt_nib = nib_info(tgt_state, tgt_step, ascii_c);
  end

  // Sequencer and bus drivers; loading a nibble always enters its SETUP cycle with E low.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= POR_WAIT;
      phase     <= PH_SETUP;
      wsel_q    <= W_PULSE;
      step      <= '0;
      cnt       <= '0;
      val_q     <= 4'h0;
      init_done <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_d     <= 4'h0;
    end else if (load_c) begin
      state <= tgt_state;
      step  <= tgt_step;
      phase <= PH_SETUP;
      cnt   <= '0;
      lcd_e <= 1'b0;
      if (state == IDLE) val_q <= value_in;
      if (tgt_state == IDLE) begin
        init_done <= 1'b1;
      end else begin
        lcd_rs <= tgt_nib.rs;
        lcd_d  <= tgt_nib.d;
        wsel_q <= tgt_nib.wsel;
      end
    end else begin
      case (state)
        POR_WAIT: cnt <= cnt + CNT_W'(1);
        INIT, WR_ADDR, WR_CHAR: begin
          case (phase)
            PH_SETUP: begin
              phase <= PH_PULSE;
              lcd_e <= 1'b1;
              cnt   <= '0;
            end
            PH_PULSE: begin
              if (pulse_last_c) begin
                phase <= PH_HOLD;
                lcd_e <= 1'b0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
            PH_HOLD: begin
              phase <= PH_WAIT;
              cnt   <= '0;
            end
            default: cnt <= cnt + CNT_W'(1);
          endcase
        end
        default: ;
      endcase
    end
  end

  assign ready  = (state == IDLE);
  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_count_lcd_writer.sv
// Bench for count_lcd_writer: per-cycle expected bus timeline built from nibble/byte timing rules,
// plus literal checks of the nibbles captured on lcd_e falling edges.
module tb_count_lcd_writer;

  localparam int unsigned E_P  = 2;
  localparam int unsigned CMD  = 5;
  localparam int unsigned CLR  = 10;
  localparam int unsigned POR  = 20;

  logic       clock;
  logic       reset;
  logic [3:0] value_in;
  logic       value_valid;
  logic       ready;
  logic       init_done;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [3:0] lcd_d;

  count_lcd_writer #(
    .E_PULSE_CYC (E_P),
    .CMD_WAIT_CYC(CMD),
    .CLR_WAIT_CYC(CLR),
    .POR_WAIT_CYC(POR)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .value_in   (value_in),
    .value_valid(value_valid),
    .ready      (ready),
    .init_done  (init_done),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_e      (lcd_e),
    .lcd_d      (lcd_d)
  );

  typedef struct packed {
    logic       e;
    logic       rdy;
    logic       done;
    logic       chk_d;
    logic       rs;
    logic [3:0] d;
  } exp_t;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } lit_t;

  exp_t exp_q[$];
  lit_t lit_q[$];
  int   cap_q[$];

  int   n_checks = 0;
  int   n_fails  = 0;
  logic prev_e   = 1'b0;

  bit   last_vld = 1'b0;
  int   last_val = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
    $fatal(1);
  end

  // Single checker: per-cycle timeline comparison, literal checks, and nibble capture on E falling.
  always @(negedge clock) begin
    exp_t x;
    lit_t l;
    if (prev_e === 1'b1 && lcd_e === 1'b0) cap_q.push_back(int'({lcd_rs, lcd_d}));
    prev_e = lcd_e;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_checks++;
      if (!(lcd_e === x.e && ready === x.rdy && init_done === x.done && lcd_rw === 1'b0 &&
            (!x.chk_d || (lcd_rs === x.rs && lcd_d === x.d)))) begin
        n_fails++;
        $display("FAIL bus_cycle t=%0t act e=%b rdy=%b done=%b rw=%b rs=%b d=%h req e=%b rdy=%b done=%b rw=0 rs=%b d=%h (chk_d=%b)",
                 $time, lcd_e, ready, init_done, lcd_rw, lcd_rs, lcd_d,
                 x.e, x.rdy, x.done, x.rs, x.d, x.chk_d);
      end
    end
    while (lit_q.size() > 0) begin
      l = lit_q.pop_front();
      n_checks++;
      if (l.act != l.exp) begin
        n_fails++;
        $display("FAIL %s act=%0d req=%0d", l.name, l.act, l.exp);
      end
    end
  end

  task automatic check_lit(input string name, input int act, input int exp);
    lit_q.push_back('{name, act, exp});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_cyc(input logic e, input logic rdy, input logic done, input logic chk,
                          input logic rs, input logic [3:0] d);
    exp_q.push_back('{e, rdy, done, chk, rs, d});
  endtask

  task automatic push_nib(input logic rs, input int d, input int wt, input logic done);
    push_cyc(1'b0, 1'b0, done, 1'b1, rs, 4'(d));
    for (int i = 0; i < int'(E_P); i++) push_cyc(1'b1, 1'b0, done, 1'b1, rs, 4'(d));
    push_cyc(1'b0, 1'b0, done, 1'b1, rs, 4'(d));
    for (int i = 0; i < wt; i++) push_cyc(1'b0, 1'b0, done, 1'b1, rs, 4'(d));
  endtask

  task automatic push_byte(input logic rs, input int b, input int long_wt, input logic done);
    push_nib(rs, (b >> 4) & 15, int'(E_P), done);
    push_nib(rs, b & 15, long_wt, done);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
  endtask

  function automatic int model_ascii(input int v);
    return (v < 10) ? 48 + v : 55 + v;
  endfunction

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    check_lit("timeline_drained", exp_q.size(), 0);
  endtask

  task automatic check_cap(input string name, input int rs, input int d);
    if (cap_q.size() == 0) check_lit(name, -1, rs * 16 + d);
    else check_lit(name, cap_q.pop_front(), rs * 16 + d);
  endtask

  task automatic check_no_more_caps(input string name);
    check_lit(name, cap_q.size(), 0);
    cap_q.delete();
  endtask

  // Reset for one edge, then expect POR silence and the full init sequence.
  task automatic do_reset();
    reset = 1'b1;
    tick();
    exp_q.delete();
    check_lit("reset_lcd_e", int'(lcd_e), 0);
    check_lit("reset_ready", int'(ready), 0);
    check_lit("reset_init_done", int'(init_done), 0);
    reset = 1'b0;
    last_vld = 1'b0;
    for (int i = 0; i < int'(POR); i++) push_cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    push_nib(1'b0, 3, int'(CLR), 1'b0);
    push_nib(1'b0, 3, int'(CLR), 1'b0);
    push_nib(1'b0, 3, int'(CLR), 1'b0);
    push_nib(1'b0, 2, int'(CLR), 1'b0);
    push_byte(1'b0, 'h28, int'(CMD), 1'b0);
    push_byte(1'b0, 'h0C, int'(CMD), 1'b0);
    push_byte(1'b0, 'h01, int'(CLR), 1'b0);
    push_byte(1'b0, 'h06, int'(CMD), 1'b0);
    push_idle(1);
    tick();
    cap_q.delete();
    wait_drain(400);
  endtask

  task automatic check_init_caps(input string name);
    int seq[12];
    seq = '{3, 3, 3, 2, 2, 8, 0, 12, 0, 1, 0, 6};
    for (int i = 0; i < 12; i++) check_cap(name, 0, seq[i]);
    check_no_more_caps({name, "_extra"});
  endtask

  // Offer a value for one cycle starting now; returns one cycle after the accepting edge.
  task automatic offer_start(input int v);
    value_in    = 4'(v);
    value_valid = 1'b1;
    push_idle(1);
`ifdef COUNT_LCD_DEDUP_EN
    if (last_vld && last_val == v) begin
      push_idle(30);
    end else begin
      push_byte(1'b0, 'h80, int'(CMD), 1'b1);
      push_byte(1'b1, model_ascii(v), int'(CMD), 1'b1);
      push_idle(1);
    end
`else
    push_byte(1'b0, 'h80, int'(CMD), 1'b1);
    push_byte(1'b1, model_ascii(v), int'(CMD), 1'b1);
    push_idle(1);
`endif
    last_vld = 1'b1;
    last_val = v;
    tick();
    value_valid = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (ready !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    wait_drain(200);
  endtask

  task automatic check_char_caps(input string name, input int v);
    int a;
    a = model_ascii(v);
    check_cap(name, 0, 8);
    check_cap(name, 0, 0);
    check_cap(name, 1, (a >> 4) & 15);
    check_cap(name, 1, a & 15);
    check_no_more_caps({name, "_extra"});
  endtask

  initial begin
    int lat;
    reset       = 1'b1;
    value_in    = 4'h0;
    value_valid = 1'b0;

    do_reset();
    check_init_caps("init_nibbles");
    check_lit("init_done_after_init", int'(init_done), 1);

    offer_start(7);
    wait_ready(lat);
    check_lit("ready_latency_7", lat, 30);
    check_char_caps("write_7", 7);
    check_lit("model_ascii_7", model_ascii(7), 'h37);

    offer_start(10);
    wait_ready(lat);
    check_char_caps("write_A", 10);
    check_lit("model_ascii_A", model_ascii(10), 'h41);
    offer_start(15);
    wait_ready(lat);
    check_char_caps("write_F", 15);
    check_lit("model_ascii_F", model_ascii(15), 'h46);

    // Strobe while busy must be ignored.
    offer_start(3);
    repeat (5) tick();
    value_in    = 4'hE;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    wait_ready(lat);
    push_idle(3);
    wait_drain(10);
    check_char_caps("busy_strobe_ignored", 3);

    // Reset during the pulse of the character high nibble.
    offer_start(9);
    repeat (16) tick();
    check_lit("pulse_before_reset", int'(lcd_e), 1);
    check_lit("rs_before_reset", int'(lcd_rs), 1);
    do_reset();
    check_init_caps("reinit_nibbles");

    offer_start(5);
    wait_ready(lat);
    check_char_caps("write_5_first", 5);
    offer_start(5);
    wait_ready(lat);
`ifdef COUNT_LCD_DEDUP_EN
    check_no_more_caps("write_5_dedup");
`else
    check_char_caps("write_5_second", 5);
`endif

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
